// File: rtl/sys_defs_pkg.sv
// Shared front-end definitions: fetch entry bundle, history width,
// default reset PC and fetch state encoding.
package sys_defs;

    localparam int GHR_BITS = 8;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         inst;
        logic                pred_taken;
        logic [31:0]         pred_target;
        logic [GHR_BITS-1:0] ghr;
    } FETCH_ENTRY;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential vs predicted target, plus the
// word-aligned redirect PC.
module fetch_next_pc (
    input  logic        [31:0] pc,
    input  logic               bp_taken,
    input  logic        [31:0] bp_target,
    input  logic        [31:0] redirect_pc,
    output logic        [31:0] next_pc,
    output logic        [31:0] redirect_aligned
);

    logic [31:0] seq_pc;

    assign seq_pc = pc + 32'd4;

    always_comb begin
        next_pc = bp_taken ? {bp_target[31:2], 2'b00} : seq_pc;
        redirect_aligned = {redirect_pc[31:2], 2'b00};
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding imem request, predictor sampling and
// ibuf push. FETCH_RESP_BYPASS_EN enables same-cycle response push.
module fetch_stage
    import sys_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          GH       = GHR_BITS
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          imem_req_o,
    output logic [31:0]   imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [31:0]   imem_rdata_i,
    input  logic          bp_taken_i,
    input  logic [31:0]   bp_target_i,
    input  logic [GH-1:0] ghr_i,
    input  logic          ibuf_full_i,
    output logic          ibuf_push_o,
    output FETCH_ENTRY    ibuf_entry_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  next_pc;
    logic [31:0]  redirect_pc;
    FETCH_ENTRY   hold_q;
    logic         granted;
    logic         latch_req;
    logic         capture;

    fetch_next_pc u_next_pc (
        .pc               (pc_q),
        .bp_taken         (bp_taken_i),
        .bp_target        (bp_target_i),
        .redirect_pc      (redirect_pc_i),
        .next_pc          (next_pc),
        .redirect_aligned (redirect_pc)
    );

    assign granted   = (state_q == FETCH_REQ) && imem_gnt_i;
    assign latch_req = granted && !flush_i;
    assign capture   = (state_q == FETCH_WAIT) && imem_rvalid_i
                       && !flush_i;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (latch_req) begin
                hold_q.pc          <= pc_q;
                hold_q.pred_taken  <= bp_taken_i;
                hold_q.pred_target <= bp_target_i;
                hold_q.ghr         <= GHR_BITS'(ghr_i);
            end
            if (capture) begin
                hold_q.inst <= imem_rdata_i;
            end
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (flush_i) begin
            pc_d = redirect_pc;
        end else if (granted) begin
            pc_d = next_pc;
        end
    end

    // A flush with a request still in flight must swallow its response.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            if (granted ||
                ((state_q == FETCH_WAIT || state_q == FETCH_DROP)
                 && !imem_rvalid_i)) begin
                state_d = FETCH_DROP;
            end else begin
                state_d = FETCH_REQ;
            end
        end else begin
            unique case (state_q)
                FETCH_REQ: begin
                    if (imem_gnt_i) state_d = FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (imem_rvalid_i) begin
`ifdef FETCH_RESP_BYPASS_EN
                        state_d = ibuf_full_i ? FETCH_HOLD : FETCH_REQ;
`else
                        state_d = FETCH_HOLD;
`endif
                    end
                end
                FETCH_HOLD: begin
                    if (!ibuf_full_i) state_d = FETCH_REQ;
                end
                FETCH_DROP: begin
                    if (imem_rvalid_i) state_d = FETCH_REQ;
                end
                default: state_d = FETCH_REQ;
            endcase
        end
    end

    always_comb begin
        imem_req_o   = 1'b0;
        ibuf_push_o  = 1'b0;
        ibuf_entry_o = hold_q;
        imem_addr_o  = pc_q;
        if (!reset) begin
            unique case (state_q)
                FETCH_REQ: imem_req_o = 1'b1;
                FETCH_WAIT: begin
`ifdef FETCH_RESP_BYPASS_EN
                    if (imem_rvalid_i && !ibuf_full_i && !flush_i) begin
                        ibuf_push_o       = 1'b1;
                        ibuf_entry_o.inst = imem_rdata_i;
                    end
`endif
                end
                FETCH_HOLD: ibuf_push_o = !ibuf_full_i && !flush_i;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage.
module tb_fetch_stage;
    import sys_defs::*;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush_i;
    logic [31:0]   redirect_pc_i;
    logic          imem_req_o;
    logic [31:0]   imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [31:0]   imem_rdata_i;
    logic          bp_taken_i;
    logic [31:0]   bp_target_i;
    logic [7:0]    ghr_i;
    logic          ibuf_full_i;
    logic          ibuf_push_o;
    FETCH_ENTRY    ibuf_entry_o;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(32'h0), .GH(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .bp_taken_i    (bp_taken_i),
        .bp_target_i   (bp_target_i),
        .ghr_i         (ghr_i),
        .ibuf_full_i   (ibuf_full_i),
        .ibuf_push_o   (ibuf_push_o),
        .ibuf_entry_o  (ibuf_entry_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        fl;
        logic [31:0] rpc;
        logic        g;
        logic        rv;
        logic [31:0] rd;
        logic        tk;
        logic [31:0] tg;
        logic        fu;
        logic [7:0]  gh;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_push;
        FETCH_ENTRY  e_ent;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic fl, logic [31:0] rpc, logic g, logic rv,
        logic [31:0] rd, logic tk, logic [31:0] tg, logic fu,
        logic [7:0] gh, logic er, logic [31:0] ea, logic ep,
        logic [31:0] epc, logic [31:0] ei, logic etk,
        logic [31:0] etg, logic [7:0] egh);
        vec_t r;
        r.fl = fl; r.rpc = rpc; r.g = g; r.rv = rv; r.rd = rd;
        r.tk = tk; r.tg = tg; r.fu = fu; r.gh = gh;
        r.e_req = er; r.e_addr = ea; r.e_push = ep;
        r.e_ent.pc = epc;
        r.e_ent.inst = ei;
        r.e_ent.pred_taken = etk;
        r.e_ent.pred_target = etg;
        r.e_ent.ghr = egh;
        return r;
    endfunction

    task automatic chk1(string name, logic [31:0] act,
                        logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, logic er, logic [31:0] ea,
                            logic ep, FETCH_ENTRY ee);
        chk1({tag, " req"}, 32'(imem_req_o), 32'(er));
        if (er) chk1({tag, " addr"}, imem_addr_o, ea);
        chk1({tag, " push"}, 32'(ibuf_push_o), 32'(ep));
        if (ep) begin
            checks++;
            if (ibuf_entry_o !== ee) begin
                errors++;
                $display("FAIL %s entry: got %h expected %h",
                         tag, ibuf_entry_o, ee);
            end
        end
    endtask

    task automatic idle_inputs();
        flush_i = 0; redirect_pc_i = 0; imem_gnt_i = 0;
        imem_rvalid_i = 0; imem_rdata_i = 0; bp_taken_i = 0;
        bp_target_i = 0; ghr_i = 0; ibuf_full_i = 0;
    endtask

    FETCH_ENTRY none;

    initial begin
        none = '0;
        reset = 1;
        idle_inputs();
        // program-order fetch from reset, sequential path
`ifdef FETCH_RESP_BYPASS_EN
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h11, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA0,0,0,0,0,
                        0,0,1,0,32'hA0,0,0,8'h11));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h22, 1,4,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA1,0,0,0,0,
                        0,0,1,4,32'hA1,0,0,8'h22));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h33, 1,8,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA2,0,0,0,0,
                        0,0,1,8,32'hA2,0,0,8'h33));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h3C,
                        1,32'hC,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA3,0,0,0,0,
                        0,0,1,32'hC,32'hA3,0,0,8'h3C));
`else
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h11, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,
                        0,0,1,0,32'hA0,0,0,8'h11));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h22, 1,4,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA1,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,
                        0,0,1,4,32'hA1,0,0,8'h22));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h33, 1,8,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA2,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,
                        0,0,1,8,32'hA2,0,0,8'h33));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h3C,
                        1,32'hC,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA3,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,
                        0,0,1,32'hC,32'hA3,0,0,8'h3C));
`endif
        // predicted-taken request, then ibuf full for several cycles
        tbl.push_back(v(0,0,1,0,0,1,32'h43,0,8'h44,
                        1,32'h10,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hA4,0,0,1,0, 0,0,0,0,0,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0,0,0,0,0,0,0,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,
                        0,0,1,32'h10,32'hA4,1,32'h43,8'h44));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,32'h40,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0,0,0, 1,32'h40,0,0,0,0,0,0));
        // flush in WAIT, stale response three cycles later
        tbl.push_back(v(1,32'h200,0,0,0,0,0,0,0,
                        0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hDEADBEEF,0,0,0,0,
                        0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0,0,0, 1,32'h200,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hB0,0,0,1,0, 0,0,0,0,0,0,0,0));
        // flush in HOLD, flush on grant, flush with same-cycle rvalid
        tbl.push_back(v(1,32'h303,0,0,0,0,0,0,0,
                        0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,32'h300,0,0,0,0,0,0));
        tbl.push_back(v(1,32'h400,1,0,0,0,0,0,0,
                        1,32'h300,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hC0,0,0,0,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0,0,0, 1,32'h400,0,0,0,0,0,0));
        tbl.push_back(v(1,32'h500,0,1,32'hC1,0,0,0,0,
                        0,0,0,0,0,0,0,0));
        // PC wrap at the top of the address space
        tbl.push_back(v(1,32'hFFFF_FFFF,0,0,0,0,0,0,0,
                        1,32'h500,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,0,0,0,0,0,8'h55,
                        1,32'hFFFF_FFFC,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,1,32'hD0,0,0,1,0, 0,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,
                        0,0,1,32'hFFFF_FFFC,32'hD0,0,0,8'h55));
        tbl.push_back(v(0,0,0,1,32'hE0,0,0,0,0, 1,0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));

        // reset cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #2;
            chk_outs("reset", 0, 0, 0, none);
        end

        @(negedge clock);
        reset = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge clock);
            flush_i       = tbl[i].fl;
            redirect_pc_i = tbl[i].rpc;
            imem_gnt_i    = tbl[i].g;
            imem_rvalid_i = tbl[i].rv;
            imem_rdata_i  = tbl[i].rd;
            bp_taken_i    = tbl[i].tk;
            bp_target_i   = tbl[i].tg;
            ibuf_full_i   = tbl[i].fu;
            ghr_i         = tbl[i].gh;
            #2;
            chk_outs($sformatf("row%0d", i), tbl[i].e_req,
                     tbl[i].e_addr, tbl[i].e_push, tbl[i].e_ent);
        end

        // reset while a request is outstanding, late rvalid ignored
        @(negedge clock);
        idle_inputs();
        imem_gnt_i = 1;
        #2;
        chk_outs("rst_wait grant", 1, 0, 0, none);
        @(negedge clock);
        idle_inputs();
        reset = 1;
        #2;
        chk_outs("rst_wait in reset", 0, 0, 0, none);
        @(negedge clock);
        reset = 0;
        imem_rvalid_i = 1;
        imem_rdata_i = 32'hEE;
        #2;
        chk_outs("rst_wait late rvalid", 1, 0, 0, none);
        @(negedge clock);
        idle_inputs();
        #2;
        chk_outs("rst_wait after", 1, 0, 0, none);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Front-end fetch stage that sits directly upstream of the instruction buffer.
- Owns the PC and issues one instruction-memory request at a time.
- Samples the branch-predictor lookup for the requested PC.
- Packs the returned instruction, PC, prediction and GHR into a FETCH_ENTRY and pushes it into the instruction buffer.
- Handles mispredict redirects, including discarding a response already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- GH, GHR_BITS, width of the global history snapshot stored per entry.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush_i  in  1  mispredict redirect; highest priority after reset.
- redirect_pc_i  in  32  new PC when flush_i is high; bits [1:0] ignored (forced to 0).
- imem_req_o  out  1  memory request valid.
- imem_addr_o  out  32  request address, equal to the current PC.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid; arrives at least 1 cycle after grant.
- imem_rdata_i  in  32  response instruction word.
- bp_taken_i  in  1  predictor taken for imem_addr_o (combinational lookup).
- bp_target_i  in  32  predicted target for imem_addr_o.
- ghr_i  in  GH  current global history.
- ibuf_full_i  in  1  instruction buffer full.
- ibuf_push_o  out  1  push strobe to the instruction buffer.
- ibuf_entry_o  out  FETCH_ENTRY  entry being pushed: pc, inst, pred_taken, pred_target, ghr.

Behaviour:
- States: REQ, WAIT, HOLD, DROP.
- Reset: state=REQ, pc=RESET_PC, imem_req_o=0 in the reset cycle, ibuf_push_o=0, hold register cleared. The first request is issued in the cycle after reset deasserts.
- REQ:
  - imem_req_o=1, imem_addr_o=pc; address held stable until grant.
  - On imem_gnt_i: latch {pc, bp_taken_i, bp_target_i, ghr_i} into the request record.
  - Also on grant: next pc = bp_taken_i ? {bp_target_i[31:2],2'b00} : pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0). Go to WAIT.
- WAIT: imem_req_o=0. On imem_rvalid_i, capture imem_rdata_i into the hold entry and go to HOLD.
- HOLD:
  - ibuf_push_o=1 and ibuf_entry_o=hold entry whenever ibuf_full_i=0.
  - On push, go to REQ.
  - While full: hold the entry, no push, no new request.
- DROP: outstanding stale request. On imem_rvalid_i, discard the data, no push, go to REQ.
- One outstanding request maximum; imem_rvalid_i outside WAIT/DROP is ignored.
- flush_i, any state:
  - pc <= {redirect_pc_i[31:2],2'b00}; ibuf_push_o forced 0 that cycle.
  - Next state is DROP if a request is outstanding: state WAIT, or REQ with imem_gnt_i this cycle. Otherwise REQ.
  - A flush in HOLD discards the held entry.
  - Flush in DROP stays in DROP with the new pc.
  - Flush in WAIT with imem_rvalid_i the same cycle goes to REQ; the data is discarded.
- reset overrides flush_i.
- Latency, non-bypass: push occurs 1 cycle after rvalid.
- Entry ordering is strictly program order along the predicted path.

Optional Feature:
- Macro FETCH_RESP_BYPASS_EN.
- When defined: in WAIT, if imem_rvalid_i=1, ibuf_full_i=0 and flush_i=0, push directly that same cycle with inst=imem_rdata_i, then go to REQ and skip HOLD. If full, fall back to HOLD.
- When undefined: every response goes through HOLD; push is never combinational from imem_rvalid_i.

Decomposition:
- Shared package (sys_defs) holds:
  - the FETCH_ENTRY typedef: pc[31:0], inst[31:0], pred_taken, pred_target[31:0], ghr[GHR_BITS-1:0];
  - GHR_BITS;
  - the default RESET_PC constant;
  - the fetch state enum.
- One natural sub-module, fetch_next_pc: combinational selection of pc+4 versus the aligned predicted target, and of the aligned redirect PC.

Test Plan:
1. Reset with RESET_PC=0, immediate grant, rvalid 1 cycle later, ibuf never full, not taken → pushes with pc=0x0, 0x4, 0x8. Push 1 cycle after rvalid, or same cycle with bypass.
2. Request at pc=0x10 with bp_taken_i=1, bp_target_i=0x43 → entry pred_taken=1, pred_target=0x43; next imem_addr_o=0x40.
3. ibuf_full_i held high 5 cycles while in HOLD → no push, no imem_req_o. Push of the held entry in the cycle full drops.
4. flush_i with redirect_pc_i=0x200 while in WAIT; stale rvalid 3 cycles later with data 0xDEADBEEF → no push of that data. Next request at 0x200.
5. flush_i while in HOLD → held entry never pushed. imem_addr_o=redirect PC the next cycle.
6. reset asserted while in WAIT → state REQ, pc=RESET_PC, ibuf_push_o=0. A late rvalid is ignored.
